vx_result_assembler: RTL and testbench
======================================

// Module: vx_result_assembler
// PURPOSE
//  Downstream of the dispatch stage, after a lane-narrow functional unit. Takes per-packet results
//  (NUM_LANES wide, tagged pid/sop/eop) and rebuilds one NUM_THREADS-wide commit entry per
//  instruction. Emits that entry on a valid/ready commit port toward writeback.
//  One instance per execute block. Input packets of one instruction arrive contiguously, sop first, eop last.
// PARAMETERS
//  NUM_LANES    4             lanes per input packet; `NUM_THREADS must be divisible by it
//  NUM_PACKETS  `NUM_THREADS/NUM_LANES  packets per full warp (derived, localparam)
//  PID_WIDTH    `UP(`CLOG2(NUM_PACKETS))  packet-id width (derived, localparam)
// PORTS
//  clk        in   1                      clock
//  reset      in   1                      synchronous, active-high
//  in_valid   in   1                      packet valid
//  in_ready   out  1                      packet accepted when in_valid && in_ready
//  in_uuid    in   `UUID_WIDTH            instruction uuid
//  in_wid     in   `NW_WIDTH              warp id
//  in_PC      in   `PC_BITS               instruction PC
//  in_rd      in   `NR_BITS               destination register
//  in_wb      in   1                      writeback enable
//  in_tmask   in   NUM_LANES              lane mask of this packet
//  in_data    in   NUM_LANES*`XLEN        lane results
//  in_pid     in   PID_WIDTH              packet index within warp
//  in_sop     in   1                      first packet of instruction
//  in_eop     in   1                      last packet of instruction
//  out_valid  out  1                      assembled entry valid
//  out_ready  in   1                      consumer ready
//  out_uuid/out_wid/out_PC/out_rd/out_wb  out  as inputs  metadata latched at sop
//  out_tmask  out  `NUM_THREADS           full thread mask
//  out_data   out  `NUM_THREADS*`XLEN     full result vector
//  proto_err  out  1                      sticky protocol-violation flag
// BEHAVIOUR
//  - Reset: state=IDLE, out_valid=0, proto_err=0, out_tmask=0. Data regs are not reset.
//  - FSM states:
//    - IDLE --sop--> COLLECT.
//    - IDLE --sop&eop--> HOLD.
//    - COLLECT --eop--> HOLD.
//    - HOLD --out fire, no same-cycle sop--> IDLE.
//  - in_ready = (state!=HOLD) || out_ready. This allows back-to-back instructions with no bubble.
//  - On accepted sop: latch metadata; clear the tmask accumulator; write this packet. The write
//    wins over the clear at slot in_pid.
//  - On accepted packet: write slot in_pid. tmask[in_pid*NUM_LANES +: NUM_LANES] <= in_tmask;
//    data slot <= in_data. Other slots are untouched.
//  - Slots never written for this instruction (skipped, all-zero packets) read tmask=0.
//    Their data is don't-care.
//  - out_valid rises the cycle after the eop packet is accepted (latency 1 from eop).
//    It holds stable until out_ready. The out_* payload is constant while out_valid=1.
//  - Simultaneous HOLD fire and sop accept: the new instruction overwrites. The state goes
//    to COLLECT, or to HOLD if that packet is also eop.
//  - NUM_PACKETS==1: every packet must have sop=eop=1, and in_pid is ignored.
//    The block acts as a 1-deep registered skid.
//  - Protocol errors (each sets proto_err, which stays 1 until reset):
//    - non-sop packet in IDLE: accepted and dropped.
//    - sop while in COLLECT: the partial entry is discarded and collection restarts on the new packet.
//    - in_wid or in_uuid differs from the latched value mid-collect: the packet is still written.
//    - pid not strictly increasing within an instruction: the packet is still written.
//  - Reset mid-collection discards the partial entry. No output is produced for it.
// STRUCTURE
//  - Shared package VX_gpu_pkg: add typedef result_pkt_t {uuid,wid,PC,rd,wb,tmask,data,pid,sop,eop}
//    and the state enum ASM_IDLE/ASM_COLLECT/ASM_HOLD.
//  - Single module, no sub-modules. The accumulator is a NUM_PACKETS x (NUM_LANES + NUM_LANES*XLEN)
//    register array, written by pid decode.
// TESTING  (NUM_THREADS=8, NUM_LANES=2 -> NUM_PACKETS=4)
//  - Full warp, pids 0..3, tmask 2'b11, data=pid*16+lane, out_ready=1
//    -> out_valid exactly 1 cycle after pid3.
//    -> out_tmask=8'hFF, out_data[t] matches the sent values, in_ready never low.
//  - Sparse warp: only pid1 (sop, tmask 2'b01) and pid3 (eop, tmask 2'b10) sent
//    -> out_tmask=8'b1000_0100.
//  - Backpressure: out_ready=0 for 5 cycles while a second sop is offered
//    -> in_ready=0 and the payload is stable.
//    -> Raising out_ready accepts the sop in the same cycle as the commit fire.
//  - Single-packet instruction (sop=eop=1, pid2, tmask 2'b11)
//    -> commit with out_tmask=8'b0011_0000 on the next cycle.
//  - Protocol errors: eop with no sop in IDLE -> proto_err=1, no out_valid.
//    Then sop on pid0 mid-collect -> restart; the commit contains only the new instruction's bits.
//  - Reset asserted after pid1 of 4 -> out_valid=0 and proto_err=0.
//    A following clean warp commits correctly.

Source files
------------

// File: rtl/vx_result_assembler_pkg.sv
// Shared definitions for the result assembler.
//   - Core-wide widths (thread count, XLEN, uuid/warp/PC/register widths).
//   - asm_state_t : collection state of the assembler.
//   - meta_t      : per-instruction metadata latched at the first packet.
//   - result_pkt_t: one lane-narrow result packet at the default lane count.
//   - up_clog2    : ceil(log2(n)), never less than 1 (a zero-width id is illegal).
package vx_result_assembler_pkg;

  localparam int NUM_THREADS = 8;
  localparam int XLEN        = 32;
  localparam int UUID_WIDTH  = 44;
  localparam int NW_WIDTH    = 2;
  localparam int PC_BITS     = 30;
  localparam int NR_BITS     = 5;

  function automatic int up_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PKT_LANES = 4;
  localparam int PKT_PID_W = up_clog2(NUM_THREADS / PKT_LANES);

  typedef enum logic [1:0] {
    ASM_IDLE    = 2'd0,
    ASM_COLLECT = 2'd1,
    ASM_HOLD    = 2'd2
  } asm_state_t;

  typedef struct packed {
    logic [UUID_WIDTH-1:0] uuid;
    logic [NW_WIDTH-1:0]   wid;
    logic [PC_BITS-1:0]    PC;
    logic [NR_BITS-1:0]    rd;
    logic                  wb;
  } meta_t;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]     uuid;
    logic [NW_WIDTH-1:0]       wid;
    logic [PC_BITS-1:0]        PC;
    logic [NR_BITS-1:0]        rd;
    logic                      wb;
    logic [PKT_LANES-1:0]      tmask;
    logic [PKT_LANES*XLEN-1:0] data;
    logic [PKT_PID_W-1:0]      pid;
    logic                      sop;
    logic                      eop;
  } result_pkt_t;

endpackage

// File: rtl/vx_result_assembler.sv
// Rebuilds one NUM_THREADS-wide commit entry from the lane-narrow packets of
// one instruction and presents it on a valid/ready commit port.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   in_valid / in_ready           packet handshake
//   in_uuid, in_wid, in_PC,
//   in_rd, in_wb                  instruction metadata (latched at sop)
//   in_tmask, in_data             lane mask and lane results of this packet
//   in_pid, in_sop, in_eop        packet index, first/last packet flags
//   out_valid / out_ready         commit handshake
//   out_uuid .. out_wb            latched metadata
//   out_tmask, out_data           full-warp mask and results
//   proto_err                     sticky protocol-violation flag
module vx_result_assembler
  import vx_result_assembler_pkg::*;
#(
  parameter  int NUM_LANES   = 4,
  localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES,
  localparam int PID_WIDTH   = up_clog2(NUM_PACKETS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [UUID_WIDTH-1:0]       in_uuid,
  input  logic [NW_WIDTH-1:0]         in_wid,
  input  logic [PC_BITS-1:0]          in_PC,
  input  logic [NR_BITS-1:0]          in_rd,
  input  logic                        in_wb,
  input  logic [NUM_LANES-1:0]        in_tmask,
  input  logic [NUM_LANES*XLEN-1:0]   in_data,
  input  logic [PID_WIDTH-1:0]        in_pid,
  input  logic                        in_sop,
  input  logic                        in_eop,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [UUID_WIDTH-1:0]       out_uuid,
  output logic [NW_WIDTH-1:0]         out_wid,
  output logic [PC_BITS-1:0]          out_PC,
  output logic [NR_BITS-1:0]          out_rd,
  output logic                        out_wb,
  output logic [NUM_THREADS-1:0]      out_tmask,
  output logic [NUM_THREADS*XLEN-1:0] out_data,
  output logic                        proto_err
);

  localparam int SLOT_W = NUM_LANES * XLEN;

  asm_state_t                 state;
  meta_t                      meta;
  logic [NUM_THREADS-1:0]     tmask_acc;
  logic [NUM_THREADS-1:0]     tmask_next;
  logic [SLOT_W-1:0]          data_acc [NUM_PACKETS];
  logic [PID_WIDTH-1:0]       last_pid;
  logic [PID_WIDTH-1:0]       slot;

  logic       fire;
  logic       accept;
  asm_state_t eff_state;
  logic       start;
  logic       cont;
  logic       drop;
  logic       write_en;
  logic       err_now;

  assign in_ready = (state != ASM_HOLD) || out_ready;
  assign fire     = out_valid && out_ready;
  assign accept   = in_valid && in_ready;

  // A commit leaving this cycle frees the entry, so an incoming packet is
  // judged as if the assembler were already idle.
  assign eff_state = fire ? ASM_IDLE : state;

  // With a single packet per warp the id carries no information.
  assign slot = (NUM_PACKETS == 1) ? '0 : in_pid;

  assign start    = accept && in_sop;
  assign cont     = accept && !in_sop && (eff_state == ASM_COLLECT);
  assign drop     = accept && !in_sop && (eff_state == ASM_IDLE);
  assign write_en = start || cont;

  assign err_now = drop
                || (start && (eff_state == ASM_COLLECT))
                || (cont && ((in_wid != meta.wid) || (in_uuid != meta.uuid)))
                || (cont && (slot <= last_pid));

  // Control: state, commit valid, sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ASM_IDLE;
      out_valid <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= proto_err | err_now;
      if (write_en && in_eop) begin
        state     <= ASM_HOLD;
        out_valid <= 1'b1;
      end else if (start) begin
        state     <= ASM_COLLECT;
        out_valid <= 1'b0;
      end else if (fire) begin
        state     <= ASM_IDLE;
        out_valid <= 1'b0;
      end
    end
  end

  // The sop clear and the slot write merge here so the write wins at in_pid.
  always_comb begin
    tmask_next = start ? '0 : tmask_acc;
    for (int p = 0; p < NUM_PACKETS; p++) begin
      if (int'(slot) == p) begin
        tmask_next[p*NUM_LANES +: NUM_LANES] = in_tmask;
      end
    end
  end

  // The mask is reset so unwritten slots of the first instruction read 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmask_acc <= '0;
    end else if (write_en) begin
      tmask_acc <= tmask_next;
    end
  end

  // Datapath: lane results, metadata, last packet id (no reset).
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PACKETS; p++) begin
      if (write_en && (int'(slot) == p)) begin
        data_acc[p] <= in_data;
      end
    end
    if (write_en) begin
      last_pid <= slot;
    end
    if (start) begin
      meta.uuid <= in_uuid;
      meta.wid  <= in_wid;
      meta.PC   <= in_PC;
      meta.rd   <= in_rd;
      meta.wb   <= in_wb;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PACKETS; p++) begin
      out_data[p*SLOT_W +: SLOT_W] = data_acc[p];
    end
  end

  assign out_tmask = tmask_acc;
  assign out_uuid  = meta.uuid;
  assign out_wid   = meta.wid;
  assign out_PC    = meta.PC;
  assign out_rd    = meta.rd;
  assign out_wb    = meta.wb;

endmodule

// File: tb/tb_vx_result_assembler.sv
// Bench for vx_result_assembler with 8 threads, 2 lanes (4 packets per warp).
// Directed scenarios followed by randomized instructions, all checked against a
// behavioural model of the commit entry kept in this file.
module tb_vx_result_assembler;
  import vx_result_assembler_pkg::*;

  localparam int NL = 2;
  localparam int NP = NUM_THREADS / NL;
  localparam int PW = up_clog2(NP);

  logic                        clk;
  logic                        reset;
  logic                        in_valid;
  logic                        in_ready;
  logic [UUID_WIDTH-1:0]       in_uuid;
  logic [NW_WIDTH-1:0]         in_wid;
  logic [PC_BITS-1:0]          in_PC;
  logic [NR_BITS-1:0]          in_rd;
  logic                        in_wb;
  logic [NL-1:0]               in_tmask;
  logic [NL*XLEN-1:0]          in_data;
  logic [PW-1:0]               in_pid;
  logic                        in_sop;
  logic                        in_eop;
  logic                        out_valid;
  logic                        out_ready;
  logic [UUID_WIDTH-1:0]       out_uuid;
  logic [NW_WIDTH-1:0]         out_wid;
  logic [PC_BITS-1:0]          out_PC;
  logic [NR_BITS-1:0]          out_rd;
  logic                        out_wb;
  logic [NUM_THREADS-1:0]      out_tmask;
  logic [NUM_THREADS*XLEN-1:0] out_data;
  logic                        proto_err;

  vx_result_assembler #(.NUM_LANES(NL)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_uuid(in_uuid), .in_wid(in_wid), .in_PC(in_PC), .in_rd(in_rd), .in_wb(in_wb),
    .in_tmask(in_tmask), .in_data(in_data), .in_pid(in_pid),
    .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_uuid(out_uuid), .out_wid(out_wid), .out_PC(out_PC), .out_rd(out_rd), .out_wb(out_wb),
    .out_tmask(out_tmask), .out_data(out_data), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what the pending commit entry should contain.
  bit                     m_hold;
  bit                     m_busy;
  bit                     m_err;
  bit [NUM_THREADS-1:0]   m_tmask;
  logic [XLEN-1:0]        m_data [NUM_THREADS];
  bit                     m_wr [NP];
  logic [UUID_WIDTH-1:0]  m_uuid;
  logic [NW_WIDTH-1:0]    m_wid;
  logic [PC_BITS-1:0]     m_pc;
  logic [NR_BITS-1:0]     m_rd;
  logic                   m_wb;
  int                     m_last;

  int  npass = 0;
  int  nfail = 0;
  int  ntotal = 0;
  bit  last_acc;
  bit  rand_ready = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hold = 0; m_busy = 0; m_err = 0; m_tmask = '0;
    for (int p = 0; p < NP; p++) m_wr[p] = 0;
  endtask

  task automatic model_write(input int pid);
    for (int l = 0; l < NL; l++) begin
      m_tmask[pid*NL + l]  = in_tmask[l];
      m_data[pid*NL + l]   = in_data[l*XLEN +: XLEN];
    end
    m_wr[pid] = 1;
    m_last    = pid;
  endtask

  task automatic model_accept();
    int pid;
    pid = int'(in_pid);
    if (in_sop) begin
      if (m_busy) m_err = 1;
      m_busy  = 1;
      m_tmask = '0;
      for (int p = 0; p < NP; p++) m_wr[p] = 0;
      m_uuid = in_uuid; m_wid = in_wid; m_pc = in_PC; m_rd = in_rd; m_wb = in_wb;
      model_write(pid);
    end else if (!m_busy) begin
      m_err = 1;
    end else begin
      if (in_wid != m_wid || in_uuid != m_uuid) m_err = 1;
      if (pid <= m_last) m_err = 1;
      model_write(pid);
    end
    if (m_busy && in_eop) begin
      m_busy = 0;
      m_hold = 1;
    end
  endtask

  task automatic check_payload();
    chk("commit_tmask", 64'(out_tmask), 64'(m_tmask));
    chk("commit_uuid", 64'(out_uuid), 64'(m_uuid));
    chk("commit_wid", 64'(out_wid), 64'(m_wid));
    chk("commit_pc", 64'(out_PC), 64'(m_pc));
    chk("commit_rd", 64'(out_rd), 64'(m_rd));
    chk("commit_wb", 64'(out_wb), 64'(m_wb));
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (m_wr[t/NL]) chk($sformatf("commit_data[%0d]", t), 64'(out_data[t*XLEN +: XLEN]), 64'(m_data[t]));
    end
  endtask

  // One clock: sample handshakes at the falling edge, advance the model at the
  // rising edge, then check the visible control outputs.
  task automatic cycle();
    bit fire, acc;
    @(negedge clk);
    fire = out_valid && out_ready && !reset;
    acc  = in_valid && in_ready && !reset;
    if (fire) check_payload();
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else begin
      if (fire) m_hold = 0;
      if (acc) model_accept();
    end
    last_acc = acc;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_hold));
    chk("proto_err", 64'(proto_err), 64'(m_err));
    chk("in_ready", 64'(in_ready), 64'(!m_hold || out_ready));
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) cycle();
  endtask

  task automatic send(input int pid, input bit sop, input bit eop, input logic [NL-1:0] tm,
                      input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1);
    bit done;
    done     = 0;
    in_valid = 1;
    in_pid   = PW'(pid);
    in_sop   = sop;
    in_eop   = eop;
    in_tmask = tm;
    in_data  = {d1, d0};
    for (int i = 0; i < 40 && !done; i++) begin
      cycle();
      done = last_acc;
    end
    if (!done) chk("send_timeout", 64'(0), 64'(1));
    in_valid = 0;
  endtask

  task automatic new_meta();
    in_uuid = {12'($urandom), $urandom};
    in_wid  = NW_WIDTH'($urandom);
    in_PC   = PC_BITS'($urandom);
    in_rd   = NR_BITS'($urandom);
    in_wb   = 1'($urandom);
  endtask

  logic [NUM_THREADS-1:0]      snap_tmask;
  logic [NUM_THREADS*XLEN-1:0] snap_data;

  initial begin
    reset = 1; in_valid = 0; out_ready = 1;
    in_uuid = '0; in_wid = '0; in_PC = '0; in_rd = '0; in_wb = 0;
    in_tmask = '0; in_data = '0; in_pid = '0; in_sop = 0; in_eop = 0;
    model_reset();
    repeat (2) cycle();
    reset = 0;
    cycle();
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_proto_err", 64'(proto_err), 64'(0));
    chk("reset_out_tmask", 64'(out_tmask), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(1));

    // Full warp, data = pid*16 + lane.
    new_meta();
    for (int p = 0; p < NP; p++) begin
      send(p, p == 0, p == NP-1, 2'b11, 32'(p*16), 32'(p*16 + 1));
      chk("full_in_ready", 64'(in_ready), 64'(1));
      chk("full_valid_timing", 64'(out_valid), 64'(p == NP-1));
    end
    chk("full_tmask", 64'(out_tmask), 64'(8'hFF));
    for (int t = 0; t < NUM_THREADS; t++)
      chk("full_data", 64'(out_data[t*XLEN +: XLEN]), 64'((t/NL)*16 + t%NL));
    idle(1);

    // Sparse warp: pid1 and pid3 only.
    new_meta();
    send(1, 1, 0, 2'b01, 32'h11, 32'h12);
    send(3, 0, 1, 2'b10, 32'h31, 32'h32);
    chk("sparse_tmask", 64'(out_tmask), 64'(8'b1000_0100));
    chk("sparse_data_t7", 64'(out_data[7*XLEN +: XLEN]), 64'(32'h32));
    idle(1);

    // Backpressure with a second sop waiting.
    out_ready = 0;
    new_meta();
    for (int p = 0; p < NP; p++) send(p, p == 0, p == NP-1, 2'($urandom), $urandom, $urandom);
    snap_tmask = out_tmask;
    snap_data  = out_data;
    new_meta();
    in_valid = 1; in_pid = '0; in_sop = 1; in_eop = 0; in_tmask = 2'b11; in_data = {32'hB1, 32'hB0};
    repeat (5) begin
      cycle();
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_no_accept", 64'(last_acc), 64'(0));
      chk("bp_tmask_stable", 64'(out_tmask), 64'(snap_tmask));
      chk("bp_data_stable", out_data[63:0], snap_data[63:0]);
    end
    out_ready = 1;
    cycle();
    chk("bp_fire_accept", 64'(last_acc), 64'(1));
    send(3, 0, 1, 2'b11, 32'hB6, 32'hB7);
    chk("bp_second_tmask", 64'(out_tmask), 64'(8'hC3));
    idle(1);

    // Single-packet instruction on pid2.
    new_meta();
    send(2, 1, 1, 2'b11, 32'h21, 32'h22);
    chk("single_valid", 64'(out_valid), 64'(1));
    chk("single_tmask", 64'(out_tmask), 64'(8'b0011_0000));
    idle(2);

    // Protocol errors: orphan eop, then sop restart mid-collect.
    send(0, 0, 1, 2'b11, 32'hE0, 32'hE1);
    chk("orphan_err", 64'(proto_err), 64'(1));
    chk("orphan_no_valid", 64'(out_valid), 64'(0));
    new_meta();
    send(1, 1, 0, 2'b11, 32'h51, 32'h52);
    send(2, 0, 0, 2'b11, 32'h53, 32'h54);
    new_meta();
    send(0, 1, 0, 2'b11, 32'h60, 32'h61);
    send(3, 0, 1, 2'b11, 32'h66, 32'h67);
    chk("restart_tmask", 64'(out_tmask), 64'(8'hC3));
    idle(1);

    // Reset mid-collection.
    new_meta();
    send(0, 1, 0, 2'b11, 32'h70, 32'h71);
    send(1, 0, 0, 2'b11, 32'h72, 32'h73);
    reset = 1;
    cycle();
    reset = 0;
    idle(2);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_proto_err", 64'(proto_err), 64'(0));
    chk("rst_tmask", 64'(out_tmask), 64'(0));
    new_meta();
    for (int p = 0; p < NP; p++) send(p, p == 0, p == NP-1, 2'b11, $urandom, $urandom);
    chk("post_rst_tmask", 64'(out_tmask), 64'(8'hFF));
    idle(1);

    // Randomized clean instructions with random consumer backpressure.
    rand_ready = 1;
    for (int n = 0; n < 40; n++) begin
      int mask, first, last;
      mask  = $urandom_range(1, (1 << NP) - 1);
      first = -1; last = -1;
      for (int p = 0; p < NP; p++) if (mask[p]) begin
        if (first < 0) first = p;
        last = p;
      end
      new_meta();
      for (int p = 0; p < NP; p++) if (mask[p])
        send(p, p == first, p == last, 2'($urandom), $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_ready = 0;
    out_ready  = 1;
    idle(3);
    chk("final_drained", 64'(out_valid), 64'(0));

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
